// File: rtl/alu_seq_multiplier_pkg.sv
// ----------------------------------------------------------------------------
// alu_mult_pkg
//   Shared types and elaboration-time helpers for the iterative shift-and-add
//   multiplier (alu_seq_multiplier) and its partial-product row.
//   Contents:
//     state_t      FSM state encoding {IDLE, RUN, DONE}
//     calc_n       number of RUN cycles per product (WIDTH / STEP)
//     count_width  width of the RUN-cycle counter, $clog2(N+1)
// ----------------------------------------------------------------------------
package alu_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_n(input int width, input int step);
        return width / step;
    endfunction

    function automatic int count_width(input int width, input int step);
        return $clog2(calc_n(width, step) + 1);
    endfunction

endpackage : alu_mult_pkg

// File: rtl/alu_seq_multiplier_if.sv
// ----------------------------------------------------------------------------
// alu_seq_multiplier_if
//   Operand/result handshake bundle between the ALU execute stage (master)
//   and the sequential multiplier (slave).
//   Signals:
//     in_valid / in_ready    operand handshake
//     in1, in2               multiplicand, multiplier (WIDTH bits)
//     is_signed              two's-complement operands; present only when
//                            ALU_SIGNED_MULT_EN is defined
//     out_valid / out_ready  product handshake; product held until taken
//     out                    2*WIDTH product
//     zero                   out == 0, qualified by out_valid
//     busy                   unit is not idle
// ----------------------------------------------------------------------------
interface alu_seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     in2;
`ifdef ALU_SIGNED_MULT_EN
    logic                 is_signed;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out;
    logic                 zero;
    logic                 busy;

    modport master (
`ifdef ALU_SIGNED_MULT_EN
        output is_signed,
`endif
        output in_valid,
        input  in_ready,
        output in1,
        output in2,
        input  out_valid,
        output out_ready,
        input  out,
        input  zero,
        input  busy
    );

    modport slave (
`ifdef ALU_SIGNED_MULT_EN
        input  is_signed,
`endif
        input  in_valid,
        output in_ready,
        input  in1,
        input  in2,
        output out_valid,
        input  out_ready,
        output out,
        output zero,
        output busy
    );

endinterface : alu_seq_multiplier_if

// File: rtl/alu_seq_multiplier_pp_row.sv
// ----------------------------------------------------------------------------
// alu_pp_row
//   Combinational partial-product row: the multiplicand is AND-masked by each
//   of the STEP low multiplier bits and the masked copies are summed, each
//   shifted by its bit position, into a WIDTH+STEP bit partial product.
//   Ports:
//     mcand  in   WIDTH        multiplicand
//     bits   in   STEP         multiplier bits retired this cycle
//     pp     out  WIDTH+STEP   partial product (unshifted by cycle count)
// ----------------------------------------------------------------------------
module alu_pp_row #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]      mcand,
    input  logic [STEP-1:0]       bits,
    output logic [WIDTH+STEP-1:0] pp
);

    localparam int PP_W = WIDTH + STEP;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so the running sum is evaluated in order and no latch
    // is inferred.
    always_comb begin
        pp = '0;
        for (int b = 0; b < STEP; b++) begin
            pp = pp + (PP_W'(mcand & {WIDTH{bits[b]}}) << b);
        end
    end

endmodule : alu_pp_row

// File: rtl/alu_seq_multiplier.sv
// ----------------------------------------------------------------------------
// alu_seq_multiplier
//   Iterative shift-and-add multiplier for the ALU execute stage. Retires STEP
//   multiplier bits per cycle, so a product takes N = WIDTH/STEP RUN cycles
//   and returns the full 2*WIDTH result. Valid/ready on both sides.
//   Optional feature macro: ALU_SIGNED_MULT_EN adds the is_signed operand
//   flag; signed products are formed from operand magnitudes and the result
//   is negated on entry to DONE (no extra cycle).
//   Parameters:
//     WIDTH  operand width, >= 2
//     STEP   multiplier bits per cycle, 1 or 2; WIDTH % STEP == 0
//   Ports:
//     clk      in   clock
//     reset_n  in   asynchronous active-low reset
//     bus      slave modport of alu_seq_multiplier_if
// ----------------------------------------------------------------------------
module alu_seq_multiplier
    import alu_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_seq_multiplier_if.slave   bus
);

    localparam int N     = calc_n(WIDTH, STEP);
    localparam int CNT_W = count_width(WIDTH, STEP);
    localparam int OUT_W = 2 * WIDTH;
    localparam int ACC_W = 2 * WIDTH + STEP;
    localparam int PP_W  = WIDTH + STEP;
    localparam int SH_W  = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N - 1);

    // Reject illegal configurations at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("alu_seq_multiplier: WIDTH must be >= 2");
    end
    if (STEP != 1 && STEP != 2) begin : g_bad_step
        $error("alu_seq_multiplier: STEP must be 1 or 2");
    end
    if (WIDTH % STEP != 0) begin : g_bad_ratio
        $error("alu_seq_multiplier: WIDTH must be a multiple of STEP");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mplier_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   count_q;
    logic [OUT_W-1:0]   out_q;

    logic               accept;
    logic               run_last;
    logic               in_ready_c;
    logic               out_valid_c;

    logic [WIDTH-1:0]   mag_in1, mag_in2;
    logic [PP_W-1:0]    pp;
    logic [SH_W-1:0]    shamt;
    logic [ACC_W-1:0]   acc_next;
    logic [OUT_W-1:0]   acc_low;
    logic [OUT_W-1:0]   result;

`ifdef ALU_SIGNED_MULT_EN
    logic               sign_q;
    logic               sign_in;

    // Signed operands are reduced to magnitudes; -2^(WIDTH-1) negates to
    // itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        mag_in1 = bus.in1;
        mag_in2 = bus.in2;
        sign_in = 1'b0;
        if (bus.is_signed) begin
            mag_in1 = bus.in1[WIDTH-1] ? -bus.in1 : bus.in1;
            mag_in2 = bus.in2[WIDTH-1] ? -bus.in2 : bus.in2;
            sign_in = bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
        end
    end
`else
    assign mag_in1 = bus.in1;
    assign mag_in2 = bus.in2;
`endif

    // ------------------------------------------------------------------
    // RUN datapath: one partial-product row, placed at bit count*STEP.
    // ------------------------------------------------------------------
    alu_pp_row #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_pp_row (
        .mcand (mcand_q),
        .bits  (mplier_q[STEP-1:0]),
        .pp    (pp)
    );

    assign shamt    = SH_W'(count_q) * SH_W'(STEP);
    assign acc_next = acc_q + (ACC_W'(pp) << shamt);
    assign acc_low  = acc_next[OUT_W-1:0];

`ifdef ALU_SIGNED_MULT_EN
    assign result = sign_q ? -acc_low : acc_low;
`else
    assign result = acc_low;
`endif

    // ------------------------------------------------------------------
    // FSM: state register and next-state / output decode.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        run_last    = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // No early exit: every product takes exactly N RUN cycles.
                if (count_q == LAST_COUNT) begin
                    run_last = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, accumulator, counter and result registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            out_q    <= '0;
`ifdef ALU_SIGNED_MULT_EN
            sign_q   <= 1'b0;
`endif
        end else if (accept) begin
            mcand_q  <= mag_in1;
            mplier_q <= mag_in2;
            acc_q    <= '0;
            count_q  <= '0;
`ifdef ALU_SIGNED_MULT_EN
            sign_q   <= sign_in;
`endif
        end else if (state_q == RUN) begin
            acc_q    <= acc_next;
            mplier_q <= mplier_q >> STEP;
            count_q  <= count_q + CNT_W'(1);
            // The result register only changes on entry to DONE, so it holds
            // its last product through DONE and the following IDLE period.
            if (run_last) begin
                out_q <= result;
            end
        end
    end

    // in_ready is held low while reset is asserted.
    assign bus.in_ready  = in_ready_c & reset_n;
    assign bus.out_valid = out_valid_c;
    assign bus.out       = out_q;
    assign bus.zero      = out_valid_c & (out_q == '0);
    assign bus.busy      = (state_q != IDLE);

endmodule : alu_seq_multiplier

// File: tb/tb_alu_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_multiplier
//   Directed bench for alu_seq_multiplier. Two instances share clk/reset_n:
//   dut (WIDTH=8, STEP=1) and dut2 (WIDTH=8, STEP=2). Expected products are
//   hand-computed constants. Inputs change on the falling edge; outputs are
//   sampled on the falling edge, away from the active rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq_multiplier;

    logic clk;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    alu_seq_multiplier_if #(.WIDTH(8)) bus  ();
    alu_seq_multiplier_if #(.WIDTH(8)) bus2 ();

    alu_seq_multiplier #(.WIDTH(8), .STEP(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    alu_seq_multiplier #(.WIDTH(8), .STEP(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One product on the STEP=1 instance. Checks latency (N=8), the product,
    // zero, and that out_valid drops after the consumer takes the result.
    // early_ready holds out_ready high from before acceptance.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sgn, input logic [15:0] exp_out,
                          input logic exp_zero, input logic early_ready);
        int lat;
        @(negedge clk);
        bus.in1      = a;
        bus.in2      = b;
`ifdef ALU_SIGNED_MULT_EN
        bus.is_signed = sgn;
`else
        if (sgn) $display("note: %s requested signed mode in an unsigned build", tag);
`endif
        bus.out_ready = early_ready;
        bus.in_valid  = 1'b1;
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);                       // accept edge has passed
        bus.in_valid = 1'b0;
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd8);
        check({tag, " out"}, 32'(bus.out), 32'(exp_out));
        check({tag, " zero"}, 32'(bus.zero), 32'(exp_zero));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, " out_kept"}, 32'(bus.out), 32'(exp_out));
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in1       = '0;
        bus2.in2       = '0;
        bus2.out_ready = 1'b0;
`ifdef ALU_SIGNED_MULT_EN
        bus.is_signed  = 1'b0;
        bus2.is_signed = 1'b0;
`endif

        // Reset state.
        reset_n = 1'b0;
        #12;
        check("rst in_ready",  32'(bus.in_ready),  32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst busy",      32'(bus.busy),      32'd0);
        check("rst out",       32'(bus.out),       32'd0);
        check("rst zero",      32'(bus.zero),      32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst in_ready", 32'(bus.in_ready), 32'd1);

        // Basic products, STEP=1.
        run_op("13x11", 8'd13, 8'd11, 1'b0, 16'd143,   1'b0, 1'b0);
        run_op("FFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01,  1'b0, 1'b0);
        // Zero operand: full latency, zero flag; out_ready high early is harmless.
        run_op("0x5A",  8'd0,  8'h5A, 1'b0, 16'd0,     1'b1, 1'b1);

        // STEP=2 instance: same FF x FF product after N=4 cycles.
        @(negedge clk);
        bus2.in1      = 8'hFF;
        bus2.in2      = 8'hFF;
        bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        lat = 0;
        while (!bus2.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("s2 latency", 32'(lat), 32'd4);
        check("s2 out", 32'(bus2.out), 32'h0000FE01);
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        check("s2 valid_drop", 32'(bus2.out_valid), 32'd0);

        // Consumer stall: 200 x 3 = 600 held 20 cycles; in_valid pulses ignored.
        @(negedge clk);
        bus.in1      = 8'd200;
        bus.in2      = 8'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("stall latency", 32'(lat), 32'd8);
        for (int i = 0; i < 20; i++) begin
            bus.in1      = 8'd9;
            bus.in2      = 8'd9;
            bus.in_valid = i[0];
            @(negedge clk);
            check("stall out_valid", 32'(bus.out_valid), 32'd1);
            check("stall out",       32'(bus.out),       32'd600);
            check("stall in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("stall release", 32'(bus.busy), 32'd0);
        run_op("3x4", 8'd3, 8'd4, 1'b0, 16'd12, 1'b0, 1'b0);

        // Reset during the 3rd RUN cycle: everything clears, no stale result.
        @(negedge clk);
        bus.in1      = 8'd100;
        bus.in2      = 8'd100;
        bus.in_valid = 1'b1;
        @(negedge clk);                       // after accept edge E
        bus.in_valid = 1'b0;
        @(negedge clk);                       // after E+1
        @(negedge clk);                       // after E+2: 3rd RUN cycle
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst busy",      32'(bus.busy),      32'd0);
        check("mid_rst out",       32'(bus.out),       32'd0);
        check("mid_rst in_ready",  32'(bus.in_ready),  32'd0);
        check("mid_rst zero",      32'(bus.zero),      32'd0);
        repeat (12) begin
            @(negedge clk);
            check("mid_rst no_valid", 32'(bus.out_valid), 32'd0);
        end
        reset_n = 1'b1;
        run_op("7x6", 8'd7, 8'd6, 1'b0, 16'd42, 1'b0, 1'b0);

`ifdef ALU_SIGNED_MULT_EN
        run_op("s -128x-1", 8'h80, 8'hFF, 1'b1, 16'h0080, 1'b0, 1'b0);
        run_op("s -3x5",    8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, 1'b0);
        run_op("u 80xFF",   8'h80, 8'hFF, 1'b0, 16'h7F80, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_seq_multiplier
